// File: rtl/leaf_dispatch_pkg.sv
// Shared types and constants for the leaf task dispatcher.
// Optional dispatch statistics are enabled with LEAF_DISPATCH_STATS_EN.
package leaf_dispatch_pkg;

    localparam int NUM_LEAVES_DEF = 5;
    localparam int LEAF_IDX_W     = $clog2(NUM_LEAVES_DEF);

    typedef logic [LEAF_IDX_W-1:0] leaf_idx_t;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Small synchronous FIFO; head is the oldest entry, valid while not empty.
// Pointers carry one wrap bit so full and empty are told apart.
module dispatch_fifo
    import leaf_dispatch_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/leaf_task_dispatcher.sv
// Round-robin, credit-limited task feeder for a five-leaf fan-out node.
// LEAF_DISPATCH_STATS_EN enables the saturating dispatch_count.
module leaf_task_dispatcher
    import leaf_dispatch_pkg::*;
#(
    parameter int NUM_LEAVES      = 5,
    parameter int DATA_W          = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic [NUM_LEAVES-1:0] out_valid,
    input  logic [NUM_LEAVES-1:0] out_ready,
    output logic [DATA_W-1:0]     out_data,
    input  logic [NUM_LEAVES-1:0] done,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           dispatch_count
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    state_t                state, state_d;
    leaf_idx_t             tgt, tgt_d, rr, sel;
    logic                  found, load, xfer;
    logic                  fifo_full, fifo_empty, push;
    logic [DATA_W-1:0]     head;
    logic [CW-1:0]         cnt [NUM_LEAVES];
    logic [NUM_LEAVES-1:0] elig, nonzero;

    assign push     = in_valid && !fifo_full;
    assign in_ready = !fifo_full;
    assign xfer     = (state == OFFER) && out_ready[tgt];

    dispatch_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (xfer),
        .wdata (in_data),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_LEAVES; i++) begin
            elig[i]    = cnt[i] < CW'(MAX_OUTSTANDING);
            nonzero[i] = cnt[i] != '0;
        end
    end

    // Scan downward so the last hit is the first eligible leaf from rr.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = rr;
        for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
            idx = (int'(rr) + k) % NUM_LEAVES;
            if (elig[idx]) begin
                found = 1'b1;
                sel   = leaf_idx_t'(idx);
            end
        end
    end

    always_comb begin
        state_d = state;
        tgt_d   = tgt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty && found) begin
                    state_d = OFFER;
                    tgt_d   = sel;
                    load    = 1'b1;
                end
            end
            OFFER: begin
                if (out_ready[tgt]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tgt       <= '0;
            rr        <= '0;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            state <= state_d;
            tgt   <= tgt_d;
            if (load) begin
                out_valid <= NUM_LEAVES'(1) << sel;
                out_data  <= head;
            end else if (xfer) begin
                out_valid <= '0;
            end
            if (xfer) begin
                rr <= (tgt == leaf_idx_t'(NUM_LEAVES - 1)) ?
                      '0 : tgt + leaf_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEAVES; i++) cnt[i] <= '0;
            err  <= 1'b0;
            busy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (xfer && tgt == leaf_idx_t'(i) && !(done[i] && nonzero[i]))
                    cnt[i] <= cnt[i] + CW'(1);
                else if (done[i] && nonzero[i] && !(xfer && tgt == leaf_idx_t'(i)))
                    cnt[i] <= cnt[i] - CW'(1);
            end
            if (|(done & ~nonzero)) err <= 1'b1;
            busy <= !fifo_empty || (|nonzero);
        end
    end

`ifdef LEAF_DISPATCH_STATS_EN
    logic [15:0] dcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dcnt <= '0;
        else if (xfer && dcnt != CNT_SAT)
            dcnt <= dcnt + 16'd1;
    end

    assign dispatch_count = dcnt;
`else
    assign dispatch_count = 16'd0;
`endif

endmodule

// File: tb/tb_leaf_task_dispatcher.sv
// Directed bench for leaf_task_dispatcher: round-robin, credits,
// backpressure, reset mid-offer, simultaneous done/issue and underflow.
module tb_leaf_task_dispatcher;

`ifdef LEAF_DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready = '0;
    logic [31:0] out_data;
    logic [4:0]  done = '0;
    logic        busy;
    logic        err;
    logic [15:0] dispatch_count;

    int checks = 0;
    int errors = 0;

    int          mon_leaf [$];
    logic [31:0] mon_data [$];

    always #5 clk = ~clk;

    leaf_task_dispatcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .done           (done),
        .busy           (busy),
        .err            (err),
        .dispatch_count (dispatch_count)
    );

    // Record every handshake that will complete on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 5; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    mon_leaf.push_back(i);
                    mon_data.push_back(out_data);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        done      = '0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_offer();
        int n = 0;
        while (out_valid == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("offer_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_done(input logic [4:0] d);
        done = d;
        @(negedge clk);
        done = '0;
    endtask

    initial begin
        int tally [5];

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dcnt", 32'(dispatch_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin over all five leaves
        out_ready = 5'b11111;
        for (int k = 0; k < 5; k++) push(32'hA0 + 32'(k));
        repeat (10) @(negedge clk);
        check("rr_n", 32'(mon_leaf.size()), 32'd5);
        for (int k = 0; k < 5 && k < mon_leaf.size(); k++) begin
            check("rr_leaf", 32'(mon_leaf[k]), 32'(k));
            check("rr_data", mon_data[k], 32'hA0 + 32'(k));
        end
        check("rr_dcnt", 32'(dispatch_count), STATS ? 32'd5 : 32'd0);
        check("rr_busy", 32'(busy), 32'd1);
        pulse_done(5'b11111);
        repeat (3) @(negedge clk);
        check("rr_idle_busy", 32'(busy), 32'd0);
        check("rr_err", 32'(err), 32'd0);

        // Credit stall: 16 tasks, 15 issued at 3 per leaf
        mon_leaf.delete();
        mon_data.delete();
        for (int k = 0; k < 16; k++) push(32'h100 + 32'(k));
        repeat (20) @(negedge clk);
        check("cr_n", 32'(mon_leaf.size()), 32'd15);
        for (int i = 0; i < 5; i++) tally[i] = 0;
        foreach (mon_leaf[k]) tally[mon_leaf[k]]++;
        for (int i = 0; i < 5; i++) check("cr_tally", 32'(tally[i]), 32'd3);
        if (mon_data.size() == 15) check("cr_last", mon_data[14], 32'h10E);
        check("cr_out_valid", 32'(out_valid), 32'd0);
        check("cr_in_ready", 32'(in_ready), 32'd1);
        check("cr_busy", 32'(busy), 32'd1);
        out_ready = '0;
        pulse_done(5'b00100);
        wait_offer();
        check("cr_retarget", 32'(out_valid), 32'b00100);
        check("cr_data", out_data, 32'h10F);

        // Reset while offering to leaf 2
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_dcnt", 32'(dispatch_count), 32'd0);

        // Backpressure: leaf 0 holds the offer, FIFO fills
        mon_leaf.delete();
        mon_data.delete();
        push(32'h55);
        wait_offer();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(out_valid), 32'b00001);
            check("bp_data", out_data, 32'h55);
            in_valid = (k < 4);
            in_data  = 32'h60 + 32'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_full", 32'(in_ready), 32'd0);
        out_ready = 5'b11111;
        repeat (12) @(negedge clk);
        check("bp_n", 32'(mon_leaf.size()), 32'd4);
        if (mon_leaf.size() == 4) begin
            check("bp_d0", mon_data[0], 32'h55);
            check("bp_d3", mon_data[3], 32'h62);
            check("bp_l3", 32'(mon_leaf[3]), 32'd3);
        end
        check("bp_dcnt", 32'(dispatch_count), STATS ? 32'd4 : 32'd0);

        // Underflow on leaf 3
        do_reset();
        pulse_done(5'b01000);
        repeat (3) @(negedge clk);
        check("uf_err", 32'(err), 32'd1);
        check("uf_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("uf_sticky", 32'(err), 32'd1);

        // Issue to leaf 1 and done[1] together with count[1]=2
        do_reset();
        check("sim_err_clr", 32'(err), 32'd0);
        mon_leaf.delete();
        mon_data.delete();
        out_ready = 5'b11111;
        for (int k = 0; k < 11; k++) push(32'h200 + 32'(k));
        repeat (10) @(negedge clk);
        check("sim_n", 32'(mon_leaf.size()), 32'd11);
        out_ready = 5'b11101;
        push(32'h77);
        wait_offer();
        check("sim_tgt", 32'(out_valid), 32'b00010);
        out_ready = 5'b11111;
        pulse_done(5'b00010);
        repeat (2) @(negedge clk);
        check("sim_xfer_n", 32'(mon_leaf.size()), 32'd12);
        if (mon_leaf.size() == 12) begin
            check("sim_xfer_leaf", 32'(mon_leaf[11]), 32'd1);
            check("sim_xfer_data", mon_data[11], 32'h77);
        end
        pulse_done(5'b00010);
        pulse_done(5'b00010);
        repeat (2) @(negedge clk);
        check("sim_cnt_ge2", 32'(err), 32'd0);
        pulse_done(5'b00010);
        repeat (2) @(negedge clk);
        check("sim_cnt_eq2", 32'(err), 32'd1);
        check("sim_dcnt", 32'(dispatch_count), STATS ? 32'd12 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
